// File: rtl/btb_assoc_pkg.sv
// Shared types, default geometry and replacement-state helpers for the branch target buffer.
package btb_assoc_pkg;

    localparam int BTB_ADDR_LEN = 32;
    localparam int BTB_IDX_SEL  = 6;
    localparam int BTB_WAYS     = 2;

    // Replacement state is sized for the largest legal associativity (4-way tree).
    localparam int PLRU_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } btb_state_e;

    typedef logic [PLRU_W-1:0] plru_t;
    typedef logic [1:0]        way_t;

    // Mark a way most-recently-used: every bit on the path points away from it.
    function automatic plru_t plru_touch(plru_t st, way_t way, int ways);
        plru_t nx;
        nx = st;
        if (ways == 2) begin
            nx[0] = ~way[0];
        end else if (ways == 4) begin
            nx[0] = ~way[1];
            if (way[1]) nx[2] = ~way[0];
            else        nx[1] = ~way[0];
        end
        return nx;
    endfunction

    // Follow the pointer bits to the least-recently-used leaf.
    function automatic way_t plru_victim(plru_t st, int ways);
        way_t v;
        v = 2'd0;
        if (ways == 2)      v = {1'b0, st[0]};
        else if (ways == 4) v = st[0] ? {1'b1, st[2]} : {1'b0, st[1]};
        return v;
    endfunction

endpackage

// File: rtl/btb_assoc_plru.sv
// Per-set pseudo-LRU state: sweep clear, MRU updates from lookup and write, victim select.
module btb_assoc_plru
    import btb_assoc_pkg::*;
#(
    parameter int WAYS    = 2,
    parameter int IDX_SEL = 6
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [IDX_SEL-1:0] clr_idx,
    input  logic               lk_en,
    input  logic [IDX_SEL-1:0] lk_idx,
    input  way_t               lk_way,
    input  logic               wr_en,
    input  logic [IDX_SEL-1:0] wr_idx,
    input  way_t               wr_way,
    input  logic [IDX_SEL-1:0] vic_idx,
    output way_t               vic_way
);

    localparam int SETS = 1 << IDX_SEL;

    plru_t st [SETS];

    assign vic_way = plru_victim(st[vic_idx], WAYS);

    // Sweep clear wins; on a same-set collision the write's touch replaces the lookup's.
    always_ff @(posedge clk) begin
        if (clr) begin
            st[clr_idx] <= '0;
        end else begin
            if (lk_en && !(wr_en && (wr_idx == lk_idx)))
                st[lk_idx] <= plru_touch(st[lk_idx], lk_way, WAYS);
            if (wr_en)
                st[wr_idx] <= plru_touch(st[wr_idx], wr_way, WAYS);
        end
    end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB for a two-instruction fetch bundle, with invalidate and sequenced flush.
module btb_assoc
    import btb_assoc_pkg::*;
#(
    parameter int ADDR_LEN = BTB_ADDR_LEN,
    parameter int IDX_SEL  = BTB_IDX_SEL,
    parameter int WAYS     = BTB_WAYS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_LEN-1:0] pc,
    input  logic                invalid2,
    output logic                hit,
    output logic                hit_slot,
    output logic [ADDR_LEN-1:0] jmpaddr,
    input  logic                we,
    input  logic                inv,
    input  logic [ADDR_LEN-1:0] jmpsrc,
    input  logic [ADDR_LEN-1:0] jmpdst,
    input  logic                flush,
    output logic                busy
);

    localparam int SETS    = 1 << IDX_SEL;
    localparam int TAG_LEN = ADDR_LEN - 3 - IDX_SEL;
    localparam logic [IDX_SEL-1:0] LAST_SET = IDX_SEL'(SETS - 1);

    logic [TAG_LEN-1:0]  tag_mem  [WAYS][SETS];
    logic                slot_mem [WAYS][SETS];
    logic [ADDR_LEN-1:0] tgt_mem  [WAYS][SETS];
    logic [SETS-1:0]     vld      [WAYS];

    btb_state_e         state;
    logic [IDX_SEL-1:0] sweep_idx;
    logic               idle, go_sweep;

    // Instruction-aligned low address bits carry no information here.
    logic unused_lsb;
    assign unused_lsb = ^{pc[1:0], jmpsrc[1:0]};

    assign idle     = (state == ST_IDLE);
    assign go_sweep = flush | ((state == ST_SWEEP) & (sweep_idx != LAST_SET));

    logic [IDX_SEL-1:0] pc_idx, wr_idx;
    logic [TAG_LEN-1:0] wr_tag;
    logic               wr_slot;
    assign pc_idx  = pc[3 +: IDX_SEL];
    assign wr_idx  = jmpsrc[3 +: IDX_SEL];
    assign wr_tag  = jmpsrc[ADDR_LEN-1 -: TAG_LEN];
    assign wr_slot = jmpsrc[2];

    logic               do_wr, do_inv;
    assign do_wr  = we & idle & ~reset;
    assign do_inv = inv & ~we & idle & ~reset;

    // Lookup stage 1: capture the fetch address and the indexed set (pre-write contents).
    logic [TAG_LEN-1:0]  lk_tag;
    logic [IDX_SEL-1:0]  lk_idx;
    logic                lk_b2, lk_inv2, lk_ok;
    logic [TAG_LEN-1:0]  rd_tag  [WAYS];
    logic                rd_slot [WAYS];
    logic [ADDR_LEN-1:0] rd_tgt  [WAYS];
    logic [WAYS-1:0]     rd_vld;

    always_ff @(posedge clk) begin
        lk_tag  <= pc[ADDR_LEN-1 -: TAG_LEN];
        lk_idx  <= pc_idx;
        lk_b2   <= pc[2];
        lk_inv2 <= invalid2;
        lk_ok   <= ~reset & idle;
        for (int w = 0; w < WAYS; w++) begin
            rd_tag[w]  <= tag_mem[w][pc_idx];
            rd_slot[w] <= slot_mem[w][pc_idx];
            rd_tgt[w]  <= tgt_mem[w][pc_idx];
            rd_vld[w]  <= vld[w][pc_idx];
        end
    end

    // Lookup stage 2: slot-0 match beats slot-1, lowest way wins within a slot.
    logic                m_hit, m_slot, hit_d;
    way_t                m_way;
    logic [ADDR_LEN-1:0] m_tgt;

    always_comb begin
        m_hit  = 1'b0;
        m_slot = 1'b0;
        m_way  = '0;
        m_tgt  = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!lk_b2 && !lk_inv2 && rd_vld[w] && (rd_tag[w] == lk_tag) && rd_slot[w]) begin
                m_hit  = 1'b1;
                m_slot = 1'b1;
                m_way  = 2'(w);
                m_tgt  = rd_tgt[w];
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (rd_vld[w] && (rd_tag[w] == lk_tag) && (rd_slot[w] == lk_b2)) begin
                m_hit  = 1'b1;
                m_slot = 1'b0;
                m_way  = 2'(w);
                m_tgt  = rd_tgt[w];
            end
        end
    end

    assign hit_d = m_hit & lk_ok & ~go_sweep & ~reset;

    // Registered prediction outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit      <= 1'b0;
            hit_slot <= 1'b0;
            jmpaddr  <= '0;
        end else begin
            hit      <= hit_d;
            hit_slot <= hit_d & m_slot;
            jmpaddr  <= hit_d ? m_tgt : '0;
        end
    end

    // Write way choice: existing tag+slot match, else lowest invalid way, else PLRU victim.
    logic [WAYS-1:0] wr_match;
    way_t            vic_way, wr_way;

    always_comb begin
        wr_match = '0;
        wr_way   = vic_way;
        for (int w = 0; w < WAYS; w++)
            wr_match[w] = vld[w][wr_idx] && (tag_mem[w][wr_idx] == wr_tag)
                          && (slot_mem[w][wr_idx] == wr_slot);
        for (int w = WAYS - 1; w >= 0; w--)
            if (!vld[w][wr_idx]) wr_way = 2'(w);
        for (int w = WAYS - 1; w >= 0; w--)
            if (wr_match[w]) wr_way = 2'(w);
    end

    // Entry storage and valid bits: sweep clear, install/update, single-entry invalidate.
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (state == ST_SWEEP)
                vld[w][sweep_idx] <= 1'b0;
            if (do_wr && (wr_way == 2'(w))) begin
                vld[w][wr_idx]      <= 1'b1;
                tag_mem[w][wr_idx]  <= wr_tag;
                slot_mem[w][wr_idx] <= wr_slot;
                tgt_mem[w][wr_idx]  <= jmpdst;
            end else if (do_inv && wr_match[w]) begin
                vld[w][wr_idx] <= 1'b0;
            end
        end
    end

    // Flush sequencer: one set cleared per cycle, restartable by flush or reset.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state     <= ST_SWEEP;
            sweep_idx <= '0;
            busy      <= 1'b1;
        end else if (state == ST_SWEEP) begin
            if (sweep_idx == LAST_SET) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                sweep_idx <= sweep_idx + 1'b1;
            end
        end
    end

    btb_assoc_plru #(
        .WAYS    (WAYS),
        .IDX_SEL (IDX_SEL)
    ) u_plru (
        .clk     (clk),
        .clr     (state == ST_SWEEP),
        .clr_idx (sweep_idx),
        .lk_en   (hit_d),
        .lk_idx  (lk_idx),
        .lk_way  (m_way),
        .wr_en   (do_wr),
        .wr_idx  (wr_idx),
        .wr_way  (wr_way),
        .vic_idx (wr_idx),
        .vic_way (vic_way)
    );

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc (IDX_SEL=6, WAYS=2) with a recency-stamp reference model.
module tb_btb_assoc;

    localparam logic [31:0] IDLE_PC = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        reset, invalid2, we, inv, flush;
    logic [31:0] pc, jmpsrc, jmpdst;
    logic        hit, hit_slot, busy;
    logic [31:0] jmpaddr;

    always #5 clk = ~clk;

    btb_assoc #(.ADDR_LEN(32), .IDX_SEL(6), .WAYS(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .pc       (pc),
        .invalid2 (invalid2),
        .hit      (hit),
        .hit_slot (hit_slot),
        .jmpaddr  (jmpaddr),
        .we       (we),
        .inv      (inv),
        .jmpsrc   (jmpsrc),
        .jmpdst   (jmpdst),
        .flush    (flush),
        .busy     (busy)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Reference model: entries per set/way, recency stamps for replacement,
    // a remaining-sweep-cycles counter, and a snapshot of the set captured by the lookup.
    function automatic int unsigned tag_of(input logic [31:0] a);
        return a >> 9;
    endfunction
    function automatic int set_of(input logic [31:0] a);
        return int'((a >> 3) & 32'h3F);
    endfunction

    bit          m_v  [64][2];
    int unsigned m_tag[64][2];
    bit          m_s  [64][2];
    logic [31:0] m_t  [64][2];
    longint      m_st [64][2];
    longint      stamp = 0;
    int          rem   = 0;

    bit          cap_ok = 0;
    logic [31:0] cap_pc = '0;
    bit          cap_i2 = 0;
    bit          cv[2];
    int unsigned ctag[2];
    bit          cs[2];
    logic [31:0] ct[2];

    logic        exp_hit = 0, exp_slot = 0, exp_busy = 1;
    logic [31:0] exp_addr = '0;
    bit          model_on = 0;

    always @(posedge clk) begin
        bit found, fsl, busy_after;
        int fw, s, ps, way;
        bit nv[2]; int unsigned ntag[2]; bit ns[2]; logic [31:0] nt[2];

        ps = set_of(pc);
        for (int w = 0; w < 2; w++) begin
            nv[w] = m_v[ps][w]; ntag[w] = m_tag[ps][w]; ns[w] = m_s[ps][w]; nt[w] = m_t[ps][w];
        end

        busy_after = reset || flush || (rem > 1);
        found = 0; fw = 0; fsl = 0;
        if (cap_ok) begin
            for (int w = 0; w < 2; w++)
                if (!found && cv[w] && ctag[w] == tag_of(cap_pc) && cs[w] == cap_pc[2]) begin
                    found = 1; fw = w; fsl = 0;
                end
            if (!cap_pc[2] && !cap_i2)
                for (int w = 0; w < 2; w++)
                    if (!found && cv[w] && ctag[w] == tag_of(cap_pc) && cs[w]) begin
                        found = 1; fw = w; fsl = 1;
                    end
        end
        if (reset || !found || busy_after) begin
            exp_hit = 0; exp_slot = 0; exp_addr = '0;
        end else begin
            exp_hit = 1; exp_slot = fsl; exp_addr = ct[fw];
            stamp++;
            m_st[set_of(cap_pc)][fw] = stamp;
        end

        if (rem > 0) begin
            s = 64 - rem;
            for (int w = 0; w < 2; w++) begin m_v[s][w] = 0; m_st[s][w] = 0; end
        end

        if (!reset && rem == 0 && we) begin
            s = set_of(jmpsrc); way = -1;
            for (int w = 0; w < 2; w++)
                if (way < 0 && m_v[s][w] && m_tag[s][w] == tag_of(jmpsrc) && m_s[s][w] == jmpsrc[2]) way = w;
            for (int w = 0; w < 2; w++)
                if (way < 0 && !m_v[s][w]) way = w;
            if (way < 0) way = (m_st[s][1] < m_st[s][0]) ? 1 : 0;
            m_v[s][way] = 1; m_tag[s][way] = tag_of(jmpsrc); m_s[s][way] = jmpsrc[2]; m_t[s][way] = jmpdst;
            stamp++;
            m_st[s][way] = stamp;
        end else if (!reset && rem == 0 && inv) begin
            s = set_of(jmpsrc);
            for (int w = 0; w < 2; w++)
                if (m_v[s][w] && m_tag[s][w] == tag_of(jmpsrc) && m_s[s][w] == jmpsrc[2]) m_v[s][w] = 0;
        end

        cap_ok = !reset && rem == 0;
        cap_pc = pc;
        cap_i2 = invalid2;
        for (int w = 0; w < 2; w++) begin cv[w] = nv[w]; ctag[w] = ntag[w]; cs[w] = ns[w]; ct[w] = nt[w]; end

        if (reset || flush) rem = 64;
        else if (rem > 0)   rem--;
        exp_busy = (rem > 0);
        if (reset) model_on = 1;
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (model_on) begin
            check("cyc_hit",      32'(hit),      32'(exp_hit));
            check("cyc_hit_slot", 32'(hit_slot), 32'(exp_slot));
            check("cyc_jmpaddr",  jmpaddr,       exp_addr);
            check("cyc_busy",     32'(busy),     32'(exp_busy));
        end
    end

    task automatic lookup(input logic [31:0] a, input logic i2, input logic eh,
                          input logic es, input logic [31:0] ea, input string name);
        pc = a; invalid2 = i2;
        @(negedge clk);
        pc = IDLE_PC; invalid2 = 0;
        @(negedge clk);
        check({name, "_hit"},      32'(hit),      32'(eh));
        check({name, "_slot"},     32'(hit_slot), 32'(es));
        check({name, "_jmpaddr"},  jmpaddr,       ea);
        check({name, "_model"},    32'(exp_hit),  32'(eh));
    endtask

    task automatic write(input logic [31:0] src, input logic [31:0] dst);
        jmpsrc = src; jmpdst = dst; we = 1;
        @(negedge clk);
        we = 0;
    endtask

    task automatic count_busy(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check(name, n, 64);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; pc = IDLE_PC; invalid2 = 0; we = 0; inv = 0; flush = 0;
        jmpsrc = '0; jmpdst = '0;
        repeat (3) @(negedge clk);
        check("rst_hit",     32'(hit),      0);
        check("rst_slot",    32'(hit_slot), 0);
        check("rst_jmpaddr", jmpaddr,       0);
        check("rst_busy",    32'(busy),     1);
        reset = 0;
        count_busy("busy_len_after_reset");
        lookup(32'h100, 0, 0, 0, 32'h0, "t1_empty");

        write(32'h104, 32'h200);
        lookup(32'h100, 0, 1, 1, 32'h200, "t2_slot1");
        lookup(32'h100, 1, 0, 0, 32'h0,   "t2_invalid2");
        lookup(32'h104, 0, 1, 0, 32'h200, "t2_slot0");

        write(32'h1F8, 32'h4444);
        lookup(32'h1F8, 0, 1, 0, 32'h4444, "last_set");

        write(32'h1000, 32'hA00);
        write(32'h2000, 32'hB00);
        lookup(32'h1000, 0, 1, 0, 32'hA00, "t3_mru");
        write(32'h3000, 32'hC00);
        lookup(32'h1000, 0, 1, 0, 32'hA00, "t3_keep");
        lookup(32'h2000, 0, 0, 0, 32'h0,   "t3_evicted");
        lookup(32'h3000, 0, 1, 0, 32'hC00, "t3_new");

        write(32'h1000, 32'h500);
        write(32'h1000, 32'h600);
        write(32'h2000, 32'h700);
        lookup(32'h1000, 0, 1, 0, 32'h600, "t4_update");
        lookup(32'h2000, 0, 1, 0, 32'h700, "t4_alloc");
        lookup(32'h3000, 0, 0, 0, 32'h0,   "t4_victim");

        jmpsrc = 32'h1000; jmpdst = 32'h600; we = 1; inv = 1;
        @(negedge clk);
        we = 0; inv = 0;
        lookup(32'h1000, 0, 1, 0, 32'h600, "t5_we_wins");
        jmpsrc = 32'h1000; inv = 1;
        @(negedge clk);
        inv = 0;
        lookup(32'h1000, 0, 0, 0, 32'h0,   "t5_inv");
        lookup(32'h2000, 0, 1, 0, 32'h700, "t5_other");

        pc = 32'h2000; flush = 1;
        @(negedge clk);
        flush = 0; pc = IDLE_PC;
        check("t6_flush_busy", 32'(busy), 1);
        @(negedge clk);
        check("t6_flush_hit", 32'(hit), 0);
        write(32'h5008, 32'h999);
        pc = 32'h1000;
        repeat (6) @(negedge clk);
        pc = IDLE_PC;
        reset = 1;
        @(negedge clk);
        reset = 0;
        count_busy("busy_len_after_sweep_reset");
        lookup(32'h1000, 0, 0, 0, 32'h0, "t6_1000");
        lookup(32'h2000, 0, 0, 0, 32'h0, "t6_2000");
        lookup(32'h100,  0, 0, 0, 32'h0, "t6_104");
        lookup(32'h1F8,  0, 0, 0, 32'h0, "t6_last_set");
        lookup(32'h5008, 0, 0, 0, 32'h0, "t6_dropped_write");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
